// File: rtl/decoder_onehot_scan.sv
// N-bit select to NUM_OUT one-hot decoder with registered outputs.
// Direct mode decodes a qualified select; scan mode walks a single active line with a programmable dwell.
module decoder_onehot_scan #(
    parameter int unsigned N          = 2,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned DWELL      = 4,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       sel,
    input  logic               sel_valid,
    output logic [NUM_OUT-1:0] y,
    output logic               y_valid,
    output logic [N-1:0]       idx,
    output logic               err,
    output logic               wrap
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned SW = N + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_OUT-1:0] y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic [N-1:0]       idx_q, idx_d;
    logic               err_q, err_d;
    logic               wrap_q, wrap_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sel_in_range_c;
    logic               last_idx_c;
    logic               dwell_done_c;

    // Output pattern for index i; act=0 gives the all-inactive pattern.
    function automatic logic [NUM_OUT-1:0] drive_pat(input logic [N-1:0] i, input logic act);
        logic [NUM_OUT-1:0] h;
        h = '0;
        for (int k = 0; k < int'(NUM_OUT); k++) begin
            h[k] = act && (i == N'(k));
        end
        return (ACTIVE_LOW != 0) ? ~h : h;
    endfunction

    // Widened compare so NUM_OUT == 2**N never flags a select as out of range.
    assign sel_in_range_c = ({1'b0, sel} < SW'(NUM_OUT));
    assign last_idx_c     = (idx_q == N'(NUM_OUT - 1));
    assign dwell_done_c   = (cnt_q == CW'(DWELL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            y_q       <= drive_pat('0, 1'b0);
            y_valid_q <= 1'b0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        idx_d     = idx_q;
        err_d     = 1'b0;
        wrap_d    = 1'b0;
        cnt_d     = cnt_q;

        if (!en) begin
            state_d   = ST_IDLE;
            y_d       = drive_pat('0, 1'b0);
            y_valid_d = 1'b0;
            idx_d     = '0;
            cnt_d     = '0;
        end else if (!mode) begin
            state_d = ST_DIRECT;
            cnt_d   = '0;
            // Any entry into direct mode starts from an empty selection.
            if (state_q != ST_DIRECT) begin
                y_d       = drive_pat('0, 1'b0);
                y_valid_d = 1'b0;
                idx_d     = '0;
            end
            if (sel_valid) begin
                if (sel_in_range_c) begin
                    y_d       = drive_pat(sel, 1'b1);
                    y_valid_d = 1'b1;
                    idx_d     = sel;
                end else begin
                    y_d       = drive_pat('0, 1'b0);
                    y_valid_d = 1'b0;
                    err_d     = 1'b1;
                end
            end
        end else begin
            state_d = ST_SCAN;
            if (state_q != ST_SCAN) begin
                idx_d     = '0;
                y_d       = drive_pat('0, 1'b1);
                y_valid_d = 1'b1;
                cnt_d     = '0;
            end else if (dwell_done_c) begin
                cnt_d     = '0;
                idx_d     = last_idx_c ? '0 : idx_q + N'(1);
                y_d       = drive_pat(idx_d, 1'b1);
                y_valid_d = 1'b1;
                wrap_d    = last_idx_c;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign idx     = idx_q;
    assign err     = err_q;
    assign wrap    = wrap_q;

endmodule
